// File: rtl/wishbone_arbiter_2m_pkg.sv
// rtl/wishbone_arbiter_2m_pkg.sv - shared codes for the two-master Wishbone arbiter
package wishbone_arbiter_2m_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_M0   = 2'd1,
    ARB_M1   = 2'd2
  } arb_state_e;

  localparam logic [1:0]  GrantNone    = 2'b00;
  localparam logic [1:0]  GrantM0      = 2'b01;
  localparam logic [1:0]  GrantM1      = 2'b10;
  localparam int          WdogW        = 8;
  localparam logic        RstEnable    = 1'b1;
  localparam logic        WriteDisable = 1'b0;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;

  function automatic logic [1:0] state_grant(input arb_state_e s);
    case (s)
      ARB_M0:  return GrantM0;
      ARB_M1:  return GrantM1;
      default: return GrantNone;
    endcase
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// rtl/wb_arb_watchdog.sv - stall counter that flags a transfer waiting TIMEOUT cycles
module wb_arb_watchdog
  import wishbone_arbiter_2m_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [WdogW-1:0] cnt_q, cnt_d;

  // clear has priority so an ack in a stalled cycle restarts the count
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i == RstEnable) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == WdogW'(TIMEOUT));

endmodule

// File: rtl/wishbone_arbiter_2m.sv
// rtl/wishbone_arbiter_2m.sv - two-master, one-slave Wishbone arbiter with stall watchdog
module wishbone_arbiter_2m
  import wishbone_arbiter_2m_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RR_EN   = 0,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [3:0]        m0_sel_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [3:0]        m1_sel_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [3:0]        s_sel_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_data_o,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_ack_i,
  output logic [1:0]        grant_o
);

  arb_state_e state_q;
  logic       last_m1_q;
  logic       own_m0, own_m1, busy, own_stb;
  logic       wd_tc, wd_fire;

  assign own_m0  = (state_q == ARB_M0);
  assign own_m1  = (state_q == ARB_M1);
  assign busy    = own_m0 | own_m1;
  assign own_stb = own_m1 ? m1_stb_i : (own_m0 & m0_stb_i);
  // a real ack in the terminal-count cycle wins over the forced error
  assign wd_fire = busy & wd_tc & ~s_ack_i;

  wb_arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk_i(clk),
    .rst_i(rst),
    .clr_i(~busy | s_ack_i | wd_fire),
    .en_i (busy & own_stb & ~s_ack_i),
    .tc_o (wd_tc)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q   <= ARB_IDLE;
      last_m1_q <= 1'b1;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (m0_cyc_i && m1_cyc_i) begin
            if (RR_EN != 0 && last_m1_q) begin
              state_q   <= ARB_M0;
              last_m1_q <= 1'b0;
            end else begin
              state_q   <= ARB_M1;
              last_m1_q <= 1'b1;
            end
          end else if (m0_cyc_i) begin
            state_q   <= ARB_M0;
            last_m1_q <= 1'b0;
          end else if (m1_cyc_i) begin
            state_q   <= ARB_M1;
            last_m1_q <= 1'b1;
          end
        end
        ARB_M0:  if (wd_fire || !m0_cyc_i) state_q <= ARB_IDLE;
        ARB_M1:  if (wd_fire || !m1_cyc_i) state_q <= ARB_IDLE;
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = WriteDisable;
    s_sel_o   = '0;
    s_addr_o  = '0;
    s_data_o  = '0;
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m0_data_o = DATA_W'(ZeroWord);
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    m1_data_o = DATA_W'(ZeroWord);
    if (own_m0) begin
      s_cyc_o   = m0_cyc_i & ~wd_fire;
      s_stb_o   = m0_stb_i & ~wd_fire;
      s_we_o    = m0_we_i;
      s_sel_o   = m0_sel_i;
      s_addr_o  = m0_addr_i;
      s_data_o  = m0_data_i;
      m0_ack_o  = s_ack_i | wd_fire;
      m0_err_o  = wd_fire;
      m0_data_o = wd_fire ? DATA_W'(ZeroWord) : s_data_i;
    end else if (own_m1) begin
      s_cyc_o   = m1_cyc_i & ~wd_fire;
      s_stb_o   = m1_stb_i & ~wd_fire;
      s_we_o    = m1_we_i;
      s_sel_o   = m1_sel_i;
      s_addr_o  = m1_addr_i;
      s_data_o  = m1_data_i;
      m1_ack_o  = s_ack_i | wd_fire;
      m1_err_o  = wd_fire;
      m1_data_o = wd_fire ? DATA_W'(ZeroWord) : s_data_i;
    end
  end

  assign grant_o = state_grant(state_q);

endmodule

// File: tb/tb_wishbone_arbiter_2m.sv
// tb/tb_wishbone_arbiter_2m.sv - bench for wishbone_arbiter_2m (fixed/TIMEOUT=8 and round-robin/TIMEOUT=4 copies)
module tb_wishbone_arbiter_2m;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
  logic [3:0]  m0_sel = 0;
  logic [31:0] m0_addr = 0, m0_wdat = 0;
  logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [3:0]  m1_sel = 0;
  logic [31:0] m1_addr = 0, m1_wdat = 0;
  logic [31:0] s_rdat = 0;
  logic        s_ack = 0;

  logic [31:0] m0_do[2], m1_do[2], s_addr[2], s_do[2];
  logic        m0_ack[2], m0_err[2], m1_ack[2], m1_err[2];
  logic        s_cyc[2], s_stb[2], s_we[2];
  logic [3:0]  s_sel[2];
  logic [1:0]  grant[2];

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  // index 0: fixed priority, TIMEOUT 8; index 1: round-robin, TIMEOUT 4
  int owner[2];
  int cnt[2];
  int last[2];

  always #5 clk = ~clk;

  wishbone_arbiter_2m #(.ADDR_W(32), .DATA_W(32), .RR_EN(0), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_addr_i(m0_addr), .m0_data_i(m0_wdat), .m0_data_o(m0_do[0]),
    .m0_ack_o(m0_ack[0]), .m0_err_o(m0_err[0]),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_addr_i(m1_addr), .m1_data_i(m1_wdat), .m1_data_o(m1_do[0]),
    .m1_ack_o(m1_ack[0]), .m1_err_o(m1_err[0]),
    .s_cyc_o(s_cyc[0]), .s_stb_o(s_stb[0]), .s_we_o(s_we[0]), .s_sel_o(s_sel[0]),
    .s_addr_o(s_addr[0]), .s_data_o(s_do[0]), .s_data_i(s_rdat), .s_ack_i(s_ack),
    .grant_o(grant[0])
  );

  wishbone_arbiter_2m #(.ADDR_W(32), .DATA_W(32), .RR_EN(1), .TIMEOUT(4)) dut_b (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_addr_i(m0_addr), .m0_data_i(m0_wdat), .m0_data_o(m0_do[1]),
    .m0_ack_o(m0_ack[1]), .m0_err_o(m0_err[1]),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_addr_i(m1_addr), .m1_data_i(m1_wdat), .m1_data_o(m1_do[1]),
    .m1_ack_o(m1_ack[1]), .m1_err_o(m1_err[1]),
    .s_cyc_o(s_cyc[1]), .s_stb_o(s_stb[1]), .s_we_o(s_we[1]), .s_sel_o(s_sel[1]),
    .s_addr_o(s_addr[1]), .s_data_o(s_do[1]), .s_data_i(s_rdat), .s_ack_i(s_ack),
    .grant_o(grant[1])
  );

  function automatic int to_of(input int k);
    return (k == 0) ? 8 : 4;
  endfunction

  function automatic logic own_cyc(input int k);
    return (owner[k] == 1) ? m0_cyc : (owner[k] == 2) ? m1_cyc : 1'b0;
  endfunction

  function automatic logic own_stb(input int k);
    return (owner[k] == 1) ? m0_stb : (owner[k] == 2) ? m1_stb : 1'b0;
  endfunction

  function automatic logic fire(input int k);
    return (owner[k] != 0) && (cnt[k] == to_of(k)) && !s_ack;
  endfunction

  function automatic int pick(input int k);
    if (m0_cyc && m1_cyc) return (k == 1 && last[k] == 2) ? 1 : 2;
    if (m0_cyc) return 1;
    if (m1_cyc) return 2;
    return 0;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        owner[k] <= 0;
        cnt[k]   <= 0;
        last[k]  <= 2;
      end else if (owner[k] == 0) begin
        cnt[k]   <= 0;
        owner[k] <= pick(k);
        if (pick(k) != 0) last[k] <= pick(k);
      end else if (fire(k) || !own_cyc(k)) begin
        owner[k] <= 0;
        cnt[k]   <= 0;
      end else begin
        cnt[k] <= s_ack ? 0 : (own_stb(k) ? cnt[k] + 1 : cnt[k]);
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got=%h expected=%h at %0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      int   x;
      logic f;
      x = owner[k];
      f = fire(k);
      chk("grant", k, 32'(grant[k]), (x == 1) ? 32'd1 : (x == 2) ? 32'd2 : 32'd0);
      chk("s_cyc", k, 32'(s_cyc[k]), 32'(!f && own_cyc(k)));
      chk("s_stb", k, 32'(s_stb[k]), 32'(!f && own_stb(k)));
      chk("s_we", k, 32'(s_we[k]), (x == 1) ? 32'(m0_we) : (x == 2) ? 32'(m1_we) : 32'd0);
      chk("s_sel", k, 32'(s_sel[k]), (x == 1) ? 32'(m0_sel) : (x == 2) ? 32'(m1_sel) : 32'd0);
      chk("s_addr", k, s_addr[k], (x == 1) ? m0_addr : (x == 2) ? m1_addr : 32'd0);
      chk("s_data", k, s_do[k], (x == 1) ? m0_wdat : (x == 2) ? m1_wdat : 32'd0);
      chk("m0_ack", k, 32'(m0_ack[k]), 32'(x == 1 && (f || s_ack)));
      chk("m0_err", k, 32'(m0_err[k]), 32'(x == 1 && f));
      chk("m0_data", k, m0_do[k], (x == 1 && !f) ? s_rdat : 32'd0);
      chk("m1_ack", k, 32'(m1_ack[k]), 32'(x == 2 && (f || s_ack)));
      chk("m1_err", k, 32'(m1_err[k]), 32'(x == 2 && f));
      chk("m1_data", k, m1_do[k], (x == 2 && !f) ? s_rdat : 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) compare_all();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL bench_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    tick();
    chk_en = 1;
    tick();
    rst = 0;
    mid();
    chk("reset_grant", 0, 32'(grant[0]), 32'd0);
    chk("reset_grant", 1, 32'(grant[1]), 32'd0);
    chk("reset_s_cyc", 0, 32'(s_cyc[0]), 32'd0);
    chk("reset_m0_ack", 1, 32'(m0_ack[1]), 32'd0);

    // single master read with 3-cycle slave wait
    tick();
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_sel = 4'hf; m0_addr = 32'h0000_0100;
    mid();
    chk("t1_pre_grant", 0, 32'(grant[0]), 32'd0);
    tick();
    mid();
    chk("t1_grant", 0, 32'(grant[0]), 32'd1);
    chk("t1_addr", 0, s_addr[0], 32'h0000_0100);
    tick(); tick(); tick();
    s_ack = 1; s_rdat = 32'hDEAD_BEEF;
    mid();
    chk("t1_rdata", 0, m0_do[0], 32'hDEAD_BEEF);
    chk("t1_ack", 0, 32'(m0_ack[0]), 32'd1);
    chk("t1_m1_ack", 0, 32'(m1_ack[0]), 32'd0);
    chk("t1_m1_data", 0, m1_do[0], 32'd0);
    tick();
    s_ack = 0; s_rdat = 0; m0_cyc = 0; m0_stb = 0;
    mid();
    chk("t1_ack_once", 0, 32'(m0_ack[0]), 32'd0);
    tick();

    // contention, fixed priority picks m1, m0 follows after one idle cycle
    tick();
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h0000_0200;
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_sel = 4'h3; m1_addr = 32'h0000_0300; m1_wdat = 32'hCAFE_0001;
    tick();
    mid();
    chk("t2_grant_m1", 0, 32'(grant[0]), 32'd2);
    chk("t2_addr_m1", 0, s_addr[0], 32'h0000_0300);
    chk("t2_wdata_m1", 0, s_do[0], 32'hCAFE_0001);
    tick();
    s_ack = 1;
    tick();
    s_ack = 0; m1_cyc = 0; m1_stb = 0;
    tick();
    mid();
    chk("t2_idle_gap", 0, 32'(grant[0]), 32'd0);
    tick();
    mid();
    chk("t2_grant_m0", 0, 32'(grant[0]), 32'd1);
    tick();
    s_ack = 1;
    tick();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    tick();

    // round-robin under continuous contention
    rst = 1;
    tick();
    rst = 0;
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      s_ack = 1;
      mid();
      chk("t3_rr_grant", 1, 32'(grant[1]), (i % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      s_ack = 0;
      if (i % 2 == 0) begin m0_cyc = 0; m0_stb = 0; end
      else begin m1_cyc = 0; m1_stb = 0; end
      tick();
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    end
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    tick(); tick();

    // no preemption while m0 waits on a slow slave
    rst = 1;
    tick();
    rst = 0;
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h0000_0400;
    tick();
    m1_cyc = 1; m1_stb = 1; m1_addr = 32'h0000_0500;
    mid();
    chk("t4_addr_hold", 0, s_addr[0], 32'h0000_0400);
    for (int w = 1; w < 5; w++) begin
      tick();
      mid();
      chk("t4_addr_hold", 0, s_addr[0], 32'h0000_0400);
      chk("t4_grant_hold", 0, 32'(grant[0]), 32'd1);
    end
    tick();
    s_ack = 1; s_rdat = 32'h0000_0055;
    mid();
    chk("t4_ack", 0, 32'(m0_ack[0]), 32'd1);
    tick();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    mid();
    chk("t4_addr_last", 0, s_addr[0], 32'h0000_0400);
    tick();
    mid();
    chk("t4_idle", 0, 32'(grant[0]), 32'd0);
    tick();
    mid();
    chk("t4_addr_m1", 0, s_addr[0], 32'h0000_0500);
    chk("t4_grant_m1", 0, 32'(grant[0]), 32'd2);
    tick();
    s_ack = 1;
    tick();
    s_ack = 0; m1_cyc = 0; m1_stb = 0;
    tick(); tick(); tick();

    // watchdog on the TIMEOUT=4 copy, then ack racing the terminal count
    rst = 1;
    tick();
    rst = 0;
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h0000_0600; s_rdat = 32'h1234_5678;
    tick();
    for (int w = 1; w < 4; w++) begin
      tick();
      mid();
      chk("t5_no_err", 1, 32'(m0_err[1]), 32'd0);
    end
    tick();
    mid();
    chk("t5_to_ack", 1, 32'(m0_ack[1]), 32'd1);
    chk("t5_to_err", 1, 32'(m0_err[1]), 32'd1);
    chk("t5_to_data", 1, m0_do[1], 32'd0);
    chk("t5_to_stb", 1, 32'(s_stb[1]), 32'd0);
    chk("t5_to_cyc", 1, 32'(s_cyc[1]), 32'd0);
    tick();
    mid();
    chk("t5_to_idle", 1, 32'(grant[1]), 32'd0);
    chk("t5_to_ack_once", 1, 32'(m0_ack[1]), 32'd0);
    tick();
    mid();
    chk("t5_regrant", 1, 32'(grant[1]), 32'd1);
    tick(); tick(); tick();
    tick();
    s_ack = 1; s_rdat = 32'hA5A5_A5A5;
    mid();
    chk("t5_race_ack", 1, 32'(m0_ack[1]), 32'd1);
    chk("t5_race_err", 1, 32'(m0_err[1]), 32'd0);
    chk("t5_race_data", 1, m0_do[1], 32'hA5A5_A5A5);
    chk("t5_race_stb", 1, 32'(s_stb[1]), 32'd1);
    tick();
    s_ack = 0; s_rdat = 0; m0_cyc = 0; m0_stb = 0;
    tick(); tick();

    // reset in the middle of an m1 transfer
    m1_cyc = 1; m1_stb = 1; m1_addr = 32'h0000_0700;
    tick();
    mid();
    chk("t6_grant_m1", 0, 32'(grant[0]), 32'd2);
    tick();
    rst = 1;
    tick();
    rst = 0;
    mid();
    for (int k = 0; k < 2; k++) begin
      chk("t6_grant", k, 32'(grant[k]), 32'd0);
      chk("t6_s_cyc", k, 32'(s_cyc[k]), 32'd0);
      chk("t6_s_addr", k, s_addr[k], 32'd0);
      chk("t6_m1_ack", k, 32'(m1_ack[k]), 32'd0);
      chk("t6_m1_err", k, 32'(m1_err[k]), 32'd0);
    end
    tick();
    m1_cyc = 0; m1_stb = 0;
    tick(); tick();
    mid();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
